touch_filter: RTL and testbench

Conditions raw FT5426 touch reports before they reach the Julia engine. Debounces the touch-registered level, clamps coordinates to the 800x480 panel, and averages a burst of samples. Emits exactly one validated `(cx, cy)` pair per physical touch. Sits between `ft5426` and `mandelbrot` in the `ft5426` clock domain.

---
 rtl/julia_pkg.sv | 19 +
 rtl/touch_filter_run_counter.sv | 29 ++
 rtl/touch_filter.sv | 148 ++++++++++++++
 tb/tb_touch_filter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// julia_pkg: shared panel geometry, touch FSM states and counter sizing helper
package julia_pkg;

  localparam int DEF_H_RES = 800;
  localparam int DEF_V_RES = 480;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    HOLD
  } touch_state_t;

  // Width needed to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/touch_filter_run_counter.sv
// run_counter: saturating count of consecutive enabled cycles, with clear
module run_counter
  import julia_pkg::*;
#(
  parameter int BOUND = 4,
  parameter int W = cnt_w(BOUND)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Clear wins; otherwise count up while enabled and stop at BOUND-1
  always_comb
    count_d = clr ? '0 : (en && count_q != W'(BOUND - 1)) ? count_q + W'(1) : count_q;

  // Count register
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;

  assign count = count_q;

endmodule

// File: rtl/touch_filter.sv
// touch_filter: debounce, clamp and average raw touch reports into one (cx, cy) per press
module touch_filter
  import julia_pkg::*;
#(
  parameter int H_RES          = DEF_H_RES,
  parameter int V_RES          = DEF_V_RES,
  parameter int SETTLE_CYCLES  = 500000,
  parameter int SAMPLE_PERIOD  = 50000,
  parameter int LOG2_SAMPLES   = 2,
  parameter int RELEASE_CYCLES = 500000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [11:0] i_px_x,
  input  logic [11:0] i_px_y,
  input  logic        i_touch_registered,
  output logic [9:0]  o_cx,
  output logic [8:0]  o_cy,
  output logic        o_valid,
  output logic        o_touch_active
);

  localparam int N   = 1 << LOG2_SAMPLES;
  localparam int SW  = cnt_w(SETTLE_CYCLES);
  localparam int RW  = cnt_w(RELEASE_CYCLES);
  localparam int PW  = cnt_w(SAMPLE_PERIOD);
  localparam int NW  = cnt_w(N);
  localparam int AXW = 10 + LOG2_SAMPLES;
  localparam int AYW = 9 + LOG2_SAMPLES;

  touch_state_t   state_q, state_d;
  logic [SW-1:0]  settle_cnt;
  logic [RW-1:0]  release_cnt;
  logic           settle_en, release_en;
  logic           settle_done, release_done;
  logic [PW-1:0]  period_q, period_d;
  logic [NW-1:0]  scnt_q, scnt_d;
  logic [AXW-1:0] acc_x_q, acc_x_d, sum_x;
  logic [AYW-1:0] acc_y_q, acc_y_d, sum_y;
  logic [9:0]     clamp_x, cx_q, cx_d;
  logic [8:0]     clamp_y, cy_q, cy_d;
  logic           valid_q, valid_d;
  logic           active_q, active_d;
  logic           tick, last;

  assign settle_en    = (state_q == SETTLE) && i_touch_registered;
  assign release_en   = (state_q == HOLD) && !i_touch_registered;
  assign settle_done  = settle_cnt == SW'(SETTLE_CYCLES - 1);
  assign release_done = release_cnt == RW'(RELEASE_CYCLES - 1);

  run_counter #(.BOUND(SETTLE_CYCLES), .W(SW)) u_settle (
    .clk   (i_Clk),
    .rst   (i_Reset),
    .clr   (!settle_en),
    .en    (settle_en),
    .count (settle_cnt)
  );

  run_counter #(.BOUND(RELEASE_CYCLES), .W(RW)) u_release (
    .clk   (i_Clk),
    .rst   (i_Reset),
    .clr   (!release_en),
    .en    (release_en),
    .count (release_cnt)
  );

  // Clamp raw coordinates to the panel and form running sums including this sample
  always_comb begin
    clamp_x = (i_px_x >= 12'(H_RES)) ? 10'(H_RES - 1) : i_px_x[9:0];
    clamp_y = (i_px_y >= 12'(V_RES)) ? 9'(V_RES - 1) : i_px_y[8:0];
    sum_x   = acc_x_q + AXW'(clamp_x);
    sum_y   = acc_y_q + AYW'(clamp_y);
    tick    = period_q == PW'(SAMPLE_PERIOD - 1);
    last    = scnt_q == NW'(N - 1);
  end

  // Next state, sampling and completion; a low touch always aborts to IDLE
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    scnt_d   = scnt_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: state_d = i_touch_registered ? SETTLE : IDLE;
      SETTLE:
        if (!i_touch_registered) state_d = IDLE;
        else if (settle_done) begin
          state_d  = SAMPLE;
          period_d = '0;
          scnt_d   = '0;
          acc_x_d  = '0;
          acc_y_d  = '0;
        end
      SAMPLE:
        if (!i_touch_registered) state_d = IDLE;
        else begin
          period_d = tick ? '0 : period_q + PW'(1);
          if (tick && last) begin
            cx_d    = 10'(sum_x >> LOG2_SAMPLES);
            cy_d    = 9'(sum_y >> LOG2_SAMPLES);
            valid_d = 1'b1;
            state_d = HOLD;
          end else if (tick) begin
            acc_x_d = sum_x;
            acc_y_d = sum_y;
            scnt_d  = scnt_q + NW'(1);
          end
        end
      HOLD: state_d = (!i_touch_registered && release_done) ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
    active_d = state_d == HOLD;
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      scnt_q   <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      scnt_q   <= scnt_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end

  assign o_cx           = cx_q;
  assign o_cy           = cy_q;
  assign o_valid        = valid_q;
  assign o_touch_active = active_q;

endmodule

// File: tb/tb_touch_filter.sv
// tb_touch_filter: directed and random touch sequences checked against an edge-offset model
module tb_touch_filter;

  localparam int S = 4;
  localparam int P = 2;
  localparam int L = 2;
  localparam int R = 3;
  localparam int N = 1 << L;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        touch = 1'b0;
  logic [11:0] px_x = '0;
  logic [11:0] px_y = '0;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic        valid;
  logic        active;

  int checks = 0;
  int errors = 0;
  int valids = 0;
  int v0;

  int m_t;
  int m_low;
  bit m_hold;
  int exp_cx;
  int exp_cy;
  bit exp_valid;
  int qx[$];
  int qy[$];

  touch_filter #(
    .SETTLE_CYCLES  (S),
    .SAMPLE_PERIOD  (P),
    .LOG2_SAMPLES   (L),
    .RELEASE_CYCLES (R)
  ) dut (
    .i_Clk              (clk),
    .i_Reset            (rst),
    .i_px_x             (px_x),
    .i_px_y             (px_y),
    .i_touch_registered (touch),
    .o_cx               (cx),
    .o_cy               (cy),
    .o_valid            (valid),
    .o_touch_active     (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    chk({tag, ".cx"}, 32'(cx), exp_cx);
    chk({tag, ".cy"}, 32'(cy), exp_cy);
    chk({tag, ".active"}, 32'(active), 32'(m_hold));
  endtask

  task automatic model_reset();
    m_t = -1;
    m_low = 0;
    m_hold = 0;
    exp_cx = 0;
    exp_cy = 0;
    exp_valid = 0;
    qx.delete();
    qy.delete();
  endtask

  // t counts edges since the press began (edge e0 has t=0); samples land at t = S + k*P
  task automatic model_edge(input bit t, input int x, input int y);
    int sx, sy;
    exp_valid = 0;
    if (m_hold) begin
      m_low = t ? 0 : m_low + 1;
      if (m_low == R) begin
        m_hold = 0;
        m_t = -1;
      end
    end else if (!t) begin
      m_t = -1;
    end else begin
      m_t++;
      if (m_t == 0) begin
        qx.delete();
        qy.delete();
      end
      if (m_t > S && (m_t - S) % P == 0) begin
        qx.push_back(x >= 800 ? 799 : x);
        qy.push_back(y >= 480 ? 479 : y);
      end
      if (m_t == S + N * P) begin
        sx = 0;
        sy = 0;
        foreach (qx[i]) begin
          sx += qx[i];
          sy += qy[i];
        end
        exp_cx = sx / N;
        exp_cy = sy / N;
        exp_valid = 1;
        m_hold = 1;
        m_low = 0;
      end
    end
  endtask

  task automatic step(input bit t, input int x, input int y);
    touch = t;
    px_x = 12'(x);
    px_y = 12'(y);
    @(posedge clk);
    model_edge(t, x, y);
    #1;
    chk_all("step");
    if (valid === 1'b1) valids++;
  endtask

  task automatic press(input int n, input int x, input int y);
    for (int i = 0; i < n; i++) step(1, x, y);
  endtask

  task automatic lift(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    int xs[4] = '{1000, 10, 20, 30};
    int ys[4] = '{600, 0, 0, 3};
    int hi, lo;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_held");
    rst = 1'b0;
    chk_all("reset_released");

    press(12, 100, 200);
    chk("clean_early_valid", 32'(valid), 0);
    press(1, 100, 200);
    chk("clean_valid", 32'(valid), 1);
    chk("clean_cx", 32'(cx), 100);
    chk("clean_cy", 32'(cy), 200);
    chk("clean_active", 32'(active), 1);
    press(1, 100, 200);
    chk("clean_pulse_len", 32'(valid), 0);
    lift(3);
    chk("clean_released", 32'(active), 0);

    press(3, 300, 100);
    lift(1);
    press(12, 300, 100);
    chk("bounce_early", 32'(valid), 0);
    press(1, 300, 100);
    chk("bounce_valid", 32'(valid), 1);
    chk("bounce_cx", 32'(cx), 300);
    lift(3);

    for (int j = 0; j <= S + N * P; j++) begin
      int k;
      k = (j <= S + P) ? 0 : (j - S - 1) / P;
      step(1, xs[k], ys[k]);
    end
    chk("clamp_valid", 32'(valid), 1);
    chk("clamp_cx", 32'(cx), 214);
    chk("clamp_cy", 32'(cy), 120);
    lift(3);

    v0 = valids;
    press(S + 2 * P + 2, 1000, 470);
    lift(1);
    chk("abort_no_valid", 32'(valid), 0);
    chk("abort_holds_cx", 32'(cx), 214);
    press(S + N * P + 1, 40, 50);
    chk("fresh_cx", 32'(cx), 40);
    chk("fresh_cy", 32'(cy), 50);
    lift(2);
    chk("hold_low2", 32'(active), 1);
    press(1, 40, 50);
    lift(2);
    chk("hold_relow2", 32'(active), 1);
    lift(1);
    chk("hold_exit", 32'(active), 0);
    chk("one_valid", 32'(valids - v0), 1);

    press(S + 2 * P + 1, 555, 333);
    #2 rst = 1'b1;
    touch = 1'b0;
    #1;
    model_reset();
    chk_all("async_reset");
    chk("async_reset_cx", 32'(cx), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_all("reset_after_sample");
    press(S + N * P + 1, 100, 200);
    chk("post_reset_cx", 32'(cx), 100);
    chk("post_reset_cy", 32'(cy), 200);
    lift(3);

    for (int r = 0; r < 40; r++) begin
      hi = $urandom_range(1, 18);
      lo = $urandom_range(1, 5);
      for (int i = 0; i < hi; i++) step(1, $urandom_range(0, 1023), $urandom_range(0, 600));
      lift(lo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
